// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared definitions for the multi-channel FIR filter.
//               Holds the FSM state encoding, index/accumulator width
//               helpers, the round-half-up constant and the signed
//               saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mac  = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;

    // Width of an index into n entries; never below 1 bit so a
    // single-entry dimension still gets a legal port width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-precision accumulator: product width plus growth from
    // summing depth terms.
    function automatic int acc_width(input int dw, input int cw, input int depth);
        return dw + cw + $clog2(depth);
    endfunction

    // Half an output LSB, added before the arithmetic shift.
    function automatic longint round_const(input int frac);
        return (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
    endfunction

    // Signed output range for a dw-bit two's complement word.
    function automatic longint sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac
// Description : Single shared multiply-accumulate datapath. One tap per
//               enabled cycle; on the last tap the finished sum is rounded
//               half-up, shifted right by FRAC_BITS and saturated into the
//               output register, which then holds until the next sample.
// Revision    : 1.0 - initial release
// Ports       : i_clk      clock (rising edge)
//               i_rst_n    synchronous active-low reset
//               i_en       process one tap this cycle
//               i_first    first tap: start from an empty accumulator
//               i_last     last tap: update the output word
//               i_sample   history sample x[n-k]
//               i_coef     coefficient h[k]
//               o_dout     rounded, saturated result
//               o_sat      result was clipped
// ============================================================================
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 18,
    parameter int FIR_DEPTH  = 16,
    parameter int FRAC_BITS  = 17
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_first,
    input  logic                         i_last,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic signed [COEF_WIDTH-1:0] i_coef,
    output logic signed [DATA_WIDTH-1:0] o_dout,
    output logic                         o_sat
);

    localparam int c_prod_w = DATA_WIDTH + COEF_WIDTH;
    localparam int c_acc_w  = acc_width(DATA_WIDTH, COEF_WIDTH, FIR_DEPTH);

    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam logic signed [c_acc_w:0] c_rnd = (c_acc_w + 1)'(round_const(FRAC_BITS));
    localparam logic signed [c_acc_w:0] c_max = (c_acc_w + 1)'(sat_max(DATA_WIDTH));
    localparam logic signed [c_acc_w:0] c_min = (c_acc_w + 1)'(sat_min(DATA_WIDTH));

    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_acc_base;
    logic signed [c_acc_w-1:0]  w_acc_next;
    logic signed [c_acc_w:0]    w_rnd;
    logic signed [c_acc_w:0]    w_shr;
    logic signed [c_acc_w-1:0]  r_acc;

    assign w_prod     = i_sample * i_coef;
    assign w_acc_base = i_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + c_acc_w'(w_prod);
    assign w_rnd      = (c_acc_w + 1)'(w_acc_next) + c_rnd;
    assign w_shr      = w_rnd >>> FRAC_BITS;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            o_dout <= '0;
            o_sat  <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
            // The last tap's sum goes straight into the output word so the
            // result is ready the cycle the FSM enters OUT.
            if (i_last) begin
                if (w_shr > c_max) begin
                    o_dout <= c_max[DATA_WIDTH-1:0];
                    o_sat  <= 1'b1;
                end else if (w_shr < c_min) begin
                    o_dout <= c_min[DATA_WIDTH-1:0];
                    o_sat  <= 1'b1;
                end else begin
                    o_dout <= w_shr[DATA_WIDTH-1:0];
                    o_sat  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mc.sv
`default_nettype none
// ============================================================================
// Module      : fir_mc
// Description : Multi-channel FIR filter. NUM_CH independent channels share
//               one coefficient set and one MAC; each accepted sample is
//               filtered over FIR_DEPTH cycles (one tap per cycle) and the
//               result is held on the output until accepted.
// Revision    : 1.0 - initial release
// Ports       : i_clk         clock (rising edge)
//               i_rst_n       synchronous active-low reset
//               iv_din        input sample (signed)
//               iv_din_ch     input channel (out-of-range maps to 0)
//               i_din_valid   input sample valid
//               o_din_ready   ready for a sample (IDLE only)
//               ov_dout       filtered, rounded, saturated output
//               ov_dout_ch    channel of ov_dout
//               o_dout_valid  output valid (OUT state)
//               i_dout_ready  output accepted
//               o_dout_sat    output was clipped
//               i_coef_we     coefficient write strobe
//               iv_coef_addr  coefficient tap index
//               iv_coef       coefficient value (signed)
//               o_coef_err    one-cycle pulse: write dropped (filter busy)
// ============================================================================
module fir_mc
    import fir_pkg::*;
#(
    parameter  int DATA_WIDTH = 24,
    parameter  int COEF_WIDTH = 18,
    parameter  int FIR_DEPTH  = 16,
    parameter  int NUM_CH     = 4,
    parameter  int FRAC_BITS  = 17,
    localparam int c_ch_w     = idx_width(NUM_CH),
    localparam int c_addr_w   = idx_width(FIR_DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic signed [DATA_WIDTH-1:0] iv_din,
    input  logic [c_ch_w-1:0]            iv_din_ch,
    input  logic                         i_din_valid,
    output logic                         o_din_ready,
    output logic signed [DATA_WIDTH-1:0] ov_dout,
    output logic [c_ch_w-1:0]            ov_dout_ch,
    output logic                         o_dout_valid,
    input  logic                         i_dout_ready,
    output logic                         o_dout_sat,
    input  logic                         i_coef_we,
    input  logic [c_addr_w-1:0]          iv_coef_addr,
    input  logic signed [COEF_WIDTH-1:0] iv_coef,
    output logic                         o_coef_err
);

    localparam logic [c_ch_w:0]     c_num_ch   = (c_ch_w + 1)'(NUM_CH);
    // Truncates to 0 for a power-of-two depth, which is exactly the modulo
    // needed by the wrap-around subtraction below.
    localparam logic [c_addr_w-1:0] c_depth    = c_addr_w'(FIR_DEPTH);
    localparam logic [c_addr_w-1:0] c_last_tap = c_addr_w'(FIR_DEPTH - 1);

    logic [1:0]                   r_state;
    logic                         r_din_rdy;
    logic                         r_coef_err;
    logic [c_ch_w-1:0]            r_ch;
    logic [c_addr_w-1:0]          r_base;
    logic [c_addr_w-1:0]          r_tap;
    logic [c_addr_w-1:0]          r_wptr [NUM_CH];
    logic signed [DATA_WIDTH-1:0] r_hist [NUM_CH][FIR_DEPTH];
    logic signed [COEF_WIDTH-1:0] r_coef [FIR_DEPTH];

    logic                         w_xfer;
    logic                         w_mac_en;
    logic                         w_first;
    logic                         w_last;
    logic [c_ch_w-1:0]            w_ch;
    logic [c_addr_w-1:0]          w_rd_addr;

    // r_din_rdy is only ever set while in IDLE, so a transfer implies IDLE.
    assign w_xfer   = i_din_valid & r_din_rdy;
    assign w_ch     = ({1'b0, iv_din_ch} < c_num_ch) ? iv_din_ch : '0;
    assign w_mac_en = (r_state == c_st_mac);
    assign w_first  = (r_tap == '0);
    assign w_last   = (r_tap == c_last_tap);

    // r_base is the slot holding x[n]; tap k reads x[n-k] = slot base-k,
    // wrapping backwards through the circular buffer.
    assign w_rd_addr = (r_base >= r_tap) ? (r_base - r_tap)
                                         : (r_base + c_depth - r_tap);

    // ------------------------------------------------------------------
    // Per-channel sample history and write pointers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c] <= '0;
                for (int k = 0; k < FIR_DEPTH; k++) begin
                    r_hist[c][k] <= '0;
                end
            end
        end else if (w_xfer) begin
            r_hist[w_ch][r_wptr[w_ch]] <= iv_din;
            r_wptr[w_ch] <= (r_wptr[w_ch] == c_last_tap) ? '0 : r_wptr[w_ch] + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank: writable only in IDLE (a write on the transfer
    // cycle lands before tap 0 is read); busy writes are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FIR_DEPTH; k++) begin
                r_coef[k] <= '0;
            end
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= i_coef_we & (r_state != c_st_idle);
            if (i_coef_we && (r_state == c_st_idle) && (iv_coef_addr <= c_last_tap)) begin
                r_coef[iv_coef_addr] <= iv_coef;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= c_st_idle;
            r_din_rdy <= 1'b0;
            r_ch      <= '0;
            r_base    <= '0;
            r_tap     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_din_rdy <= ~w_xfer;
                    if (w_xfer) begin
                        r_state <= c_st_mac;
                        r_ch    <= w_ch;
                        r_base  <= r_wptr[w_ch];
                        r_tap   <= '0;
                    end
                end
                c_st_mac: begin
                    if (w_last) begin
                        r_state <= c_st_out;
                        r_tap   <= '0;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                c_st_out: begin
                    if (i_dout_ready) begin
                        r_state   <= c_st_idle;
                        r_din_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_din_rdy <= 1'b0;
                end
            endcase
        end
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .FIR_DEPTH  (FIR_DEPTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_mac_en),
        .i_first  (w_first),
        .i_last   (w_last),
        .i_sample (r_hist[r_ch][w_rd_addr]),
        .i_coef   (r_coef[r_tap]),
        .o_dout   (ov_dout),
        .o_sat    (o_dout_sat)
    );

    assign o_din_ready  = r_din_rdy;
    assign o_dout_valid = (r_state == c_st_out);
    assign ov_dout_ch   = r_ch;
    assign o_coef_err   = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_mc
// Description : Self-checking bench for fir_mc (16-bit data/coef, 8 taps,
//               2 channels, no fractional bits). A shift-register reference
//               model pushes expected results to a scoreboard as samples
//               are driven; they are popped when the DUT presents output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mc;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int DEPTH = 8;
    localparam int NCH   = 2;
    localparam int FRAC  = 0;
    localparam int CH_W  = 1;
    localparam int AD_W  = 3;
    localparam longint DMAX = 32767;
    localparam longint DMIN = -32768;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] din;
    logic [CH_W-1:0]      din_ch;
    logic                 din_valid;
    logic                 din_ready;
    logic signed [DW-1:0] dout;
    logic [CH_W-1:0]      dout_ch;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_sat;
    logic                 coef_we;
    logic [AD_W-1:0]      coef_addr;
    logic signed [CW-1:0] coef;
    logic                 coef_err;

    always #5 clk = ~clk;

    fir_mc #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .FIR_DEPTH  (DEPTH),
        .NUM_CH     (NCH),
        .FRAC_BITS  (FRAC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .iv_din       (din),
        .iv_din_ch    (din_ch),
        .i_din_valid  (din_valid),
        .o_din_ready  (din_ready),
        .ov_dout      (dout),
        .ov_dout_ch   (dout_ch),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_dout_sat   (dout_sat),
        .i_coef_we    (coef_we),
        .iv_coef_addr (coef_addr),
        .iv_coef      (coef),
        .o_coef_err   (coef_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int     ch;
        longint data;
        bit     sat;
    } exp_t;

    exp_t   sb[$];
    longint m_coef [DEPTH];
    longint m_hist [NCH][DEPTH];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_coef[k] = 0;
            for (int c = 0; c < NCH; c++) m_hist[c][k] = 0;
        end
        sb.delete();
    endtask

    // Reference: shift-register history, direct convolution, then clip.
    task automatic model_push(input int ch, input longint x);
        longint acc;
        exp_t   e;
        for (int k = DEPTH - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = x;
        acc = 0;
        for (int k = 0; k < DEPTH; k++) acc += m_coef[k] * m_hist[ch][k];
        e.ch  = ch;
        e.sat = 1'b0;
        e.data = acc;
        if (acc > DMAX) begin e.data = DMAX; e.sat = 1'b1; end
        if (acc < DMIN) begin e.data = DMIN; e.sat = 1'b1; end
        sb.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; coef_we = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_sat",   dout_sat,   0);
        check("rst_coef_err",   coef_err,   0);
        check("rst_dout",       dout,       0);
        check("rst_dout_ch",    dout_ch,    0);
        check("rst_din_ready",  din_ready,  0);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic wr_coef(input int addr, input longint val);
        coef_we = 1'b1; coef_addr = AD_W'(addr); coef = CW'(val);
        m_coef[addr] = val;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_idle", coef_err, 0);
    endtask

    // Drive one sample, optionally with a coefficient write on the same
    // cycle or one during MAC, then collect and score its output.
    task automatic send(input int ch, input longint x, input int hold,
                        input bit we_same, input int w_addr, input longint w_val,
                        input bit we_mid);
        int   n;
        bit   stable;
        exp_t e;
        logic signed [DW-1:0] held;
        n = 0;
        while (!din_ready && n < 20) begin @(negedge clk); n++; end
        if (!din_ready) begin check("din_ready_timeout", 0, 1); return; end
        din = DW'(x); din_ch = CH_W'(ch); din_valid = 1'b1;
        if (we_same) begin
            coef_we = 1'b1; coef_addr = AD_W'(w_addr); coef = CW'(w_val);
            m_coef[w_addr] = w_val;
        end
        model_push(ch, x);
        n = 0;
        do begin
            @(negedge clk); n++;
            din_valid = 1'b0; coef_we = 1'b0;
            if (we_mid && n == 3) begin coef_we = 1'b1; coef_addr = '0; coef = 16'sd5; end
            if (we_mid && n == 4) check("coef_err_pulse", coef_err, 1);
            if (we_mid && n == 5) check("coef_err_clear", coef_err, 0);
            if (n < DEPTH + 1) begin
                if (din_ready) begin check("busy_din_ready", din_ready, 0); end
            end
        end while (!dout_valid && n < 40);
        if (!dout_valid) begin check("dout_valid_timeout", 0, 1); return; end
        check("latency", n, DEPTH + 1);
        if (sb.size() == 0) begin check("scoreboard_empty", 0, 1); return; end
        e = sb.pop_front();
        check("dout",    dout,    e.data);
        check("dout_ch", dout_ch, e.ch);
        check("dout_sat", dout_sat, e.sat);
        if (hold > 0) begin
            held = dout; stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (dout !== held || !dout_valid || din_ready || dout_ch != CH_W'(e.ch)) stable = 1'b0;
            end
            check("backpressure_hold", stable, 1);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check("valid_drop", dout_valid, 0);
    endtask

    task automatic reset_mid();
        bit seen;
        int n;
        n = 0;
        while (!din_ready && n < 20) begin @(negedge clk); n++; end
        din = 16'sd77; din_ch = '0; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_din_ready",  din_ready,  0);
        rst_n = 1'b1;
        model_clear();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dout_valid) seen = 1'b1;
        end
        check("midrst_no_stale_out", seen, 0);
    endtask

    initial begin
        din = '0; din_ch = '0; din_valid = 1'b0; dout_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef = '0; rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset(2);

        // Cleared coefficients give zero output
        send(0, 100, 0, 0, 0, 0, 0);

        // Impulse: h[k]=k+1, last coefficient written on the transfer cycle
        for (int k = 0; k < DEPTH - 1; k++) wr_coef(k, k + 1);
        send(0, 1, 0, 1, DEPTH - 1, DEPTH, 0);
        for (int i = 0; i < DEPTH; i++) send(0, 0, 0, 0, 0, 0, 0);

        // Channel isolation: interleaved ch0 impulse and ch1 zeros
        for (int i = 0; i <= DEPTH; i++) begin
            send(0, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
            send(1, 0, 0, 0, 0, 0, 0);
        end

        // Backpressure then a follow-up sample on the same channel
        send(1, 5, 10, 0, 0, 0, 0);
        send(1, 3, 0, 0, 0, 0, 0);

        // Coefficient write during MAC is dropped
        send(0, 2, 0, 0, 0, 0, 1);
        send(0, 1, 0, 0, 0, 0, 0);

        // Saturation at both rails, crossing through an unclipped region
        for (int k = 0; k < DEPTH; k++) wr_coef(k, 1000);
        for (int i = 0; i < DEPTH; i++) send(0, DMAX, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) send(0, DMIN, 0, 0, 0, 0, 0);

        // Reset mid-MAC, zero output before reload, then clean impulse
        reset_mid();
        send(0, 200, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) wr_coef(k, k + 1);
        send(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
